io_input_conditioner: RTL and testbench
=======================================

IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles required to accept a button change (10 ms at 100 MHz).
REQ-002 SHALL have parameter CNT_W, default 20, meaning debounce counter width; DEBOUNCE_CYCLES-1 SHALL fit in CNT_W bits.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port btn_raw  input  5  asynchronous push-button pins.
REQ-006 SHALL have port sw_raw  input  16  asynchronous slide-switch pins.
REQ-007 SHALL have port io_address  input  32  CPU IO address.
REQ-008 SHALL have port io_read_en  input  1  CPU IO read strobe.
REQ-009 SHALL have port io_write_en  input  1  CPU IO write strobe.
REQ-010 SHALL have port io_write_value  input  32  CPU IO write data.
REQ-011 SHALL have port io_read_value  output  32  registered read data returned to CPU.
REQ-012 SHALL have port btn_level  output  5  debounced button levels.
REQ-013 SHALL have port sw_level  output  16  synchronized switch levels.
REQ-014 SHALL have port press_irq  output  1  high while any press-event bit is set.

Function
REQ-015 SHALL pass every btn_raw and sw_raw bit through a two-flop synchronizer; the second flop output is "sync".
REQ-016 SHALL drive sw_level directly from the switch sync flops (no debounce; raw-to-sw_level latency 2 cycles).
REQ-017 SHALL keep, per button, an independent CNT_W-bit counter and a stable bit driving btn_level[i].
REQ-018 SHALL clear counter i in any cycle where sync[i] equals stable[i].
REQ-019 SHALL increment counter i when sync[i] differs from stable[i] and counter i < DEBOUNCE_CYCLES-1.
REQ-020 SHALL, when sync[i] differs and counter i == DEBOUNCE_CYCLES-1, load stable[i] <= sync[i] and clear counter i; total raw-to-btn_level latency = 2 + DEBOUNCE_CYCLES cycles.
REQ-021 SHALL reject any sync glitch shorter than DEBOUNCE_CYCLES cycles (counter restarts from 0 on return to stable value); counter SHALL never wrap.
REQ-022 SHALL set press_events[i] in the cycle after stable[i] transitions 0->1; releases (1->0) SHALL NOT set events.
REQ-023 SHALL clear press_events[i] when io_write_en is high, io_address == 3 and io_write_value[i] == 1 (write-1-to-clear); bits written 0 unchanged.
REQ-024 SHALL give set priority over clear when a press edge and a clear for the same bit occur in the same cycle (bit remains 1).
REQ-025 SHALL drive press_irq as a register equal to OR of press_events, one cycle behind press_events.
REQ-026 SHALL, when io_read_en is high, register io_read_value next edge: address 1 -> {16'b0, sw_level}; 2 -> {16'b0, btn_level, 11'b0}; 3 -> {27'b0, press_events}; any other -> 32'b0.
REQ-027 SHALL hold io_read_value unchanged in cycles with io_read_en low; read latency is exactly 1 cycle; reads SHALL have no side effects.
REQ-028 SHALL ignore writes to any address other than 3, and ignore io_write_value[31:5] at address 3.

Reset
REQ-029 SHALL, while reset is high at a clk edge, clear synchronizers, counters, stable bits, press_events, btn_level, sw_level, press_irq and io_read_value to 0.
REQ-030 SHALL, on reset mid-debounce, discard the in-progress count; a button held through reset SHALL be re-qualified (2 + DEBOUNCE_CYCLES cycles) and SHALL produce a press event.
REQ-031 SHALL give reset priority over all set, clear and read activity in the same cycle.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 SHALL verify: btn_raw[0] 0->1 held -> btn_level[0]=1 exactly 6 cycles later, press_events=5'b00001, press_irq=1 one cycle after.
REQ-033 SHALL verify: btn_raw[1] pulse high 3 cycles then low -> btn_level stays 0, press_events stays 0.
REQ-034 SHALL verify: sw_raw=16'hA5C3, then read address 1 -> io_read_value=32'h0000A5C3 one cycle after io_read_en; read address 2 with btn_level=5'b10001 -> 32'h00008800; read address 7 -> 0.
REQ-035 SHALL verify: press_events=5'b00011, write 32'h1 to address 3 -> press_events=5'b00010; write 32'h2 same cycle as new press on bit 1 -> bit 1 remains 1.
REQ-036 SHALL verify: reset asserted at counter=2 with button held -> all outputs 0 next edge; after release of reset, btn_level[0]=1 after 6 cycles and press event set.
REQ-037 SHALL verify: io_read_en low for 10 cycles while inputs change -> io_read_value unchanged.

Source files
------------

// File: rtl/io_input_conditioner.sv
// Board input conditioning: synchronizes switches and buttons, debounces buttons,
// latches button presses as write-1-to-clear events and exposes all of it on the CPU IO bus.
module io_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  btn_raw,
    input  logic [15:0] sw_raw,
    input  logic [31:0] io_address,
    input  logic        io_read_en,
    input  logic        io_write_en,
    input  logic [31:0] io_write_value,
    output logic [31:0] io_read_value,
    output logic [4:0]  btn_level,
    output logic [15:0] sw_level,
    output logic        press_irq
);

    localparam int NBTN = 5;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [31:0] ADDR_SW    = 32'd1;
    localparam logic [31:0] ADDR_BTN   = 32'd2;
    localparam logic [31:0] ADDR_PRESS = 32'd3;

    logic [4:0]       btn_meta_r;
    logic [4:0]       btn_sync_r;
    logic [15:0]      sw_meta_r;
    logic [15:0]      sw_sync_r;
    logic [CNT_W-1:0] cnt_r [NBTN];
    logic [CNT_W-1:0] cnt_nxt_s [NBTN];
    logic [4:0]       stable_r;
    logic [4:0]       stable_nxt_s;
    logic [4:0]       stable_d_r;
    logic [4:0]       press_events_r;
    logic [4:0]       events_nxt_s;
    logic [4:0]       rise_s;
    logic [4:0]       clear_s;
    logic             press_irq_r;
    logic [31:0]      read_value_r;
    logic [31:0]      read_nxt_s;
    logic             unused_s;

    assign unused_s = ^io_write_value[31:5];

    // Per-button debounce: count while sync disagrees with stable, accept at the limit.
    always_comb begin
        stable_nxt_s = stable_r;
        for (int i = 0; i < NBTN; i++) begin
            cnt_nxt_s[i] = CNT_ZERO;
            if (btn_sync_r[i] == stable_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] >= CNT_MAX) begin
                // >= rather than == keeps the counter from ever wrapping
                stable_nxt_s[i] = btn_sync_r[i];
                cnt_nxt_s[i]    = CNT_ZERO;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Press events: rising edges of the debounced level set, CPU writes of 1 clear; set wins.
    always_comb begin
        rise_s = stable_r & ~stable_d_r;
        if (io_write_en && (io_address == ADDR_PRESS)) begin
            clear_s = io_write_value[4:0];
        end else begin
            clear_s = 5'b00000;
        end
        events_nxt_s = (press_events_r & ~clear_s) | rise_s;
    end

    // CPU read mux; the returned value only changes on a read strobe.
    always_comb begin
        read_nxt_s = read_value_r;
        if (io_read_en) begin
            case (io_address)
                ADDR_SW:    read_nxt_s = {16'h0000, sw_sync_r};
                ADDR_BTN:   read_nxt_s = {16'h0000, stable_r, 11'b000_0000_0000};
                ADDR_PRESS: read_nxt_s = {27'h000_0000, press_events_r};
                default:    read_nxt_s = 32'h0000_0000;
            endcase
        end else begin
            read_nxt_s = read_value_r;
        end
    end

    // All state registers; reset overrides every other update.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_r     <= 5'b00000;
            btn_sync_r     <= 5'b00000;
            sw_meta_r      <= 16'h0000;
            sw_sync_r      <= 16'h0000;
            stable_r       <= 5'b00000;
            stable_d_r     <= 5'b00000;
            press_events_r <= 5'b00000;
            press_irq_r    <= 1'b0;
            read_value_r   <= 32'h0000_0000;
            for (int i = 0; i < NBTN; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            btn_meta_r     <= btn_raw;
            btn_sync_r     <= btn_meta_r;
            sw_meta_r      <= sw_raw;
            sw_sync_r      <= sw_meta_r;
            stable_r       <= stable_nxt_s;
            stable_d_r     <= stable_r;
            press_events_r <= events_nxt_s;
            press_irq_r    <= |press_events_r;
            read_value_r   <= read_nxt_s;
            for (int i = 0; i < NBTN; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign btn_level     = stable_r;
    assign sw_level      = sw_sync_r;
    assign press_irq     = press_irq_r;
    assign io_read_value = read_value_r;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Self-checking bench for io_input_conditioner with DEBOUNCE_CYCLES=4; register reads
// are checked through a queue of expected values popped one cycle after each read strobe.
module tb_io_input_conditioner;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  btn_raw;
    logic [15:0] sw_raw;
    logic [31:0] io_address;
    logic        io_read_en;
    logic        io_write_en;
    logic [31:0] io_write_value;
    logic [31:0] io_read_value;
    logic [4:0]  btn_level;
    logic [15:0] sw_level;
    logic        press_irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_due;

    always #5 clk = ~clk;

    io_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .io_address(io_address), .io_read_en(io_read_en), .io_write_en(io_write_en),
        .io_write_value(io_write_value), .io_read_value(io_read_value),
        .btn_level(btn_level), .sw_level(sw_level), .press_irq(press_irq)
    );

    // Scoreboard side: a read accepted at an edge must show its value 1 cycle later.
    always @(posedge clk) begin
        rd_due = io_read_en & ~reset;
        #1;
        if (rd_due) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL read_unexpected: io_read_value=%h required no pending read", io_read_value);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (io_read_value !== e) begin
                    failures++;
                    $display("FAIL %s: io_read_value=%h required %h", n, io_read_value, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        io_address = addr;
        io_read_en = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        tick(1);
        io_read_en = 1'b0;
        io_address = 32'd0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] val);
        io_address     = addr;
        io_write_value = val;
        io_write_en    = 1'b1;
        tick(1);
        io_write_en    = 1'b0;
        io_address     = 32'd0;
        io_write_value = 32'd0;
    endtask

    task automatic test_reset;
        reset = 1'b1; btn_raw = 5'h1F; sw_raw = 16'hFFFF;
        tick(3);
        checks++; if (btn_level !== 5'b00000) begin failures++; $display("FAIL rst_btn: %b required 00000", btn_level); end
        checks++; if (sw_level !== 16'h0000) begin failures++; $display("FAIL rst_sw: %h required 0000", sw_level); end
        checks++; if (press_irq !== 1'b0) begin failures++; $display("FAIL rst_irq: %b required 0", press_irq); end
        checks++; if (io_read_value !== 32'h0) begin failures++; $display("FAIL rst_rd: %h required 0", io_read_value); end
        btn_raw = 5'b00000; sw_raw = 16'h0000;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_press;
        btn_raw = 5'b00001;
        tick(5);
        checks++; if (btn_level !== 5'b00000) begin failures++; $display("FAIL press_early: %b required 00000", btn_level); end
        tick(1);
        checks++; if (btn_level !== 5'b00001) begin failures++; $display("FAIL press_level: %b required 00001", btn_level); end
        checks++; if (press_irq !== 1'b0) begin failures++; $display("FAIL press_irq_early: %b required 0", press_irq); end
        tick(2);
        checks++; if (press_irq !== 1'b1) begin failures++; $display("FAIL press_irq: %b required 1", press_irq); end
        issue_read(32'd3, 32'h0000_0001, "press_events");
    endtask

    task automatic test_glitch;
        btn_raw = 5'b00011;
        tick(3);
        btn_raw = 5'b00001;
        tick(10);
        checks++; if (btn_level !== 5'b00001) begin failures++; $display("FAIL glitch_level: %b required 00001", btn_level); end
        issue_read(32'd3, 32'h0000_0001, "glitch_events");
    endtask

    task automatic test_read;
        sw_raw = 16'hA5C3;
        tick(1);
        checks++; if (sw_level !== 16'h0000) begin failures++; $display("FAIL sw_latency: %h required 0000", sw_level); end
        tick(1);
        checks++; if (sw_level !== 16'hA5C3) begin failures++; $display("FAIL sw_level: %h required a5c3", sw_level); end
        issue_read(32'd1, 32'h0000_A5C3, "read_sw");
        btn_raw = 5'b10001;
        tick(8);
        checks++; if (btn_level !== 5'b10001) begin failures++; $display("FAIL btn_level4: %b required 10001", btn_level); end
        issue_read(32'd2, 32'h0000_8800, "read_btn");
        issue_read(32'd7, 32'h0000_0000, "read_other");
        issue_read(32'd3, 32'h0000_0011, "read_events");
    endtask

    task automatic test_clear;
        do_write(32'd3, 32'h0000_0010);
        btn_raw = 5'b10011;
        tick(8);
        issue_read(32'd3, 32'h0000_0003, "events_0011");
        do_write(32'd3, 32'h0000_0001);
        issue_read(32'd3, 32'h0000_0002, "clear_bit0");
        do_write(32'd4, 32'h0000_001F);
        do_write(32'h0000_0103, 32'h0000_001F);
        issue_read(32'd3, 32'h0000_0002, "write_other_addr");
        do_write(32'd3, 32'hFFFF_FFE0);
        issue_read(32'd3, 32'h0000_0002, "write_upper_bits");
        do_write(32'd3, 32'h0000_0002);
        issue_read(32'd3, 32'h0000_0000, "clear_bit1");
        checks++; if (press_irq !== 1'b0) begin failures++; $display("FAIL irq_cleared: %b required 0", press_irq); end
        btn_raw = 5'b10001;
        tick(8);
        issue_read(32'd3, 32'h0000_0000, "release_no_event");
        btn_raw = 5'b10011;
        tick(6);
        io_address = 32'd3; io_write_value = 32'h0000_0002; io_write_en = 1'b1;
        tick(1);
        io_write_en = 1'b0; io_address = 32'd0; io_write_value = 32'd0;
        issue_read(32'd3, 32'h0000_0002, "set_beats_clear");
        tick(1);
        checks++; if (press_irq !== 1'b1) begin failures++; $display("FAIL irq_after_set: %b required 1", press_irq); end
    endtask

    task automatic test_hold;
        issue_read(32'd1, 32'h0000_A5C3, "hold_prime");
        for (int k = 0; k < 10; k++) begin
            sw_raw     = 16'($urandom);
            io_address = 32'($urandom_range(0, 7));
            tick(1);
            checks++;
            if (io_read_value !== 32'h0000_A5C3) begin
                failures++;
                $display("FAIL hold_%0d: %h required 0000a5c3", k, io_read_value);
            end
        end
        io_address = 32'd0;
        sw_raw = 16'h00FF;
    endtask

    task automatic test_reset_mid;
        btn_raw = 5'b00000;
        tick(8);
        checks++; if (press_irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq: %b required 1", press_irq); end
        btn_raw = 5'b00001;
        tick(4);
        reset = 1'b1; io_read_en = 1'b1; io_address = 32'd1;
        tick(1);
        checks++; if (btn_level !== 5'b00000) begin failures++; $display("FAIL mid_rst_btn: %b required 00000", btn_level); end
        checks++; if (sw_level !== 16'h0000) begin failures++; $display("FAIL mid_rst_sw: %h required 0000", sw_level); end
        checks++; if (press_irq !== 1'b0) begin failures++; $display("FAIL mid_rst_irq: %b required 0", press_irq); end
        checks++; if (io_read_value !== 32'h0) begin failures++; $display("FAIL mid_rst_rd: %h required 0", io_read_value); end
        reset = 1'b0; io_read_en = 1'b0; io_address = 32'd0;
        tick(5);
        checks++; if (btn_level !== 5'b00000) begin failures++; $display("FAIL requal_early: %b required 00000", btn_level); end
        checks++; if (sw_level !== 16'h00FF) begin failures++; $display("FAIL requal_sw: %h required 00ff", sw_level); end
        tick(1);
        checks++; if (btn_level !== 5'b00001) begin failures++; $display("FAIL requal_level: %b required 00001", btn_level); end
        tick(2);
        checks++; if (press_irq !== 1'b1) begin failures++; $display("FAIL requal_irq: %b required 1", press_irq); end
        issue_read(32'd3, 32'h0000_0001, "requal_events");
    endtask

    initial begin
        reset = 1'b1; btn_raw = 5'b00000; sw_raw = 16'h0000;
        io_address = 32'd0; io_read_en = 1'b0; io_write_en = 1'b0; io_write_value = 32'd0;
        test_reset();
        test_press();
        test_glitch();
        test_read();
        test_clear();
        test_hold();
        test_reset_mid();
        tick(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL reads_outstanding: %0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
